icache_rd_server: RTL and testbench
===================================

// Module: icache_rd_server
// PURPOSE
// - Instruction-cache responder: the producing end of the icache_rd_resp stream that wavefront_controller consumes.
// - Accepts per-wave fetch requests and returns one instruction dword per request.
// - Direct-mapped and blocking; refills whole lines from a memory read port on a miss.
// - Sits between the wavefront controllers (fetch side) and the L1/memory fabric.
// PARAMETERS
// - ADDR_WIDTH   32  byte-address width of the PC
// - WAVE_ID_W    4   width of the wave tag carried request->response
// - NUM_LINES    64  number of cache lines; power of two
// - LINE_WORDS   4   32-bit words per line; power of two, >=2
// PORTS
// - clk             input   1                          core clock
// - rst_n           input   1                          asynchronous active-low reset
// - icache_rd_req   decoupled_intr.slave   ICACHE_REQ_SIZE    {wave_id, pc}
// - icache_rd_resp  decoupled_intr.master  ICACHE_RESP_SIZE   {wave_id, pc, inst[31:0]}
// - mem_rd_req      decoupled_intr.master  ADDR_WIDTH         line-aligned byte address
// - mem_rd_resp     decoupled_intr.slave   32                 one refill word per beat, ascending order
// - inv_all         input   1                          pulse: invalidate all lines
// BEHAVIOUR
// - Clock and reset: single clock clk. rst_n is asynchronous, active-low.
// - Reset state:
//   - FSM in IDLE; all valid bits cleared; inv_pending=0.
//   - Outputs at reset: icache_rd_req.ready=0, icache_rd_resp.valid=0, icache_rd_resp.data=0, mem_rd_req.valid=0, mem_rd_req.data=0, mem_rd_resp.ready=0.
// - Handshake rules:
//   - Transfer occurs on valid&&ready at a rising clk edge.
//   - valid and data are held stable until accepted.
// - Address split:
//   - pc[1:0] ignored.
//   - off = pc[2 +: log2(LINE_WORDS)].
//   - idx = next log2(NUM_LINES) bits.
//   - tag = the remaining upper bits.
// - FSM states: IDLE, LOOKUP, RESP, REFILL_REQ, REFILL_WAIT.
//   - IDLE: req.ready=1 iff !inv_pending. On transfer, latch the request, issue the tag/data RAM read, go to LOOKUP.
//   - LOOKUP: RAM outputs are valid this cycle.
//     - Hit (valid[idx] && tag match): register inst, go to RESP.
//     - Miss: go to REFILL_REQ.
//   - RESP: resp.valid=1. On acceptance go to IDLE.
//   - REFILL_REQ: mem_rd_req.valid=1, data={tag,idx,0s}. On acceptance: clear the beat counter, clear valid[idx], go to REFILL_WAIT.
//   - REFILL_WAIT: mem_rd_resp.ready=1.
//     - Each beat writes data[idx][beat] and increments the beat counter.
//     - On the last beat (beat==LINE_WORDS-1): write tag[idx] and set valid[idx]. Forward the requested word straight into the resp register (it was captured when beat==off) and go to RESP. No replay lookup.
// - Latency:
//   - Hit: response valid 2 cycles after the request transfer (T accept, T+1 LOOKUP, T+2 RESP).
//   - Miss: response valid 1 cycle after the last refill beat.
// - Throughput: at most one request in flight. req.ready=0 in every state except IDLE.
// - Backpressure: resp.ready low holds RESP indefinitely, with data stable; no further requests are accepted meanwhile.
// - Invalidate:
//   - inv_all in IDLE clears all valid bits on the next edge, and req.ready=0 in that cycle.
//   - inv_all in any other state sets inv_pending. The clear happens on entry to IDLE.
//   - A line being refilled when inv_all arrives is still returned to the requester, then invalidated.
// - Simultaneous inv_all and req.valid in IDLE: the invalidate wins and the request waits one cycle.
// - Reset mid-refill: the FSM returns to IDLE, all lines are invalid, and the beat counter is 0. The memory side is reset on the same rst_n, so no stale beats arrive.
// - Bounds: the beat counter is log2(LINE_WORDS) bits. Wrap is impossible because the FSM exits on the last beat.
// STRUCTURE
// - Shared package icache_pkg:
//   - ICACHE_REQ_SIZE, ICACHE_RESP_SIZE.
//   - typedef structs icache_req_t and icache_resp_t (packed, wave_id MSBs).
//   - enum icache_state_e.
// - Sub-module icache_data_ram: single-port synchronous RAM, NUM_LINES*LINE_WORDS x 32, 1-cycle read, byte-free word write.
// - Tag and valid arrays live in flops in the top module, so reset and invalidate act on them directly.
// TESTING
// - Cold miss, pc=0x100, wave 3 (idx=16, off=0):
//   - Expect mem_rd_req 0x100.
//   - Feed beats 0xA0..0xA3.
//   - Expect resp {3,0x100,0xA0} one cycle after the 4th beat.
// - Hit after fill, pc=0x108, wave 5:
//   - Expect resp {5,0x108,0xA2} exactly 2 cycles after accept.
//   - Expect no mem_rd_req.
// - Conflict, pc=0x500 (same idx=16, tag 1):
//   - Expect a refill from 0x500.
//   - Expect a subsequent pc=0x100 to miss again.
// - Backpressure: hold resp.ready=0 for 10 cycles during RESP.
//   - Expect resp.data stable.
//   - Expect req.ready=0 throughout.
//   - Expect release on the first ready.
// - inv_all during REFILL_WAIT:
//   - Expect the in-flight response to be correct.
//   - A repeat of the same pc then misses.
//   - inv_all with req.valid in IDLE delays acceptance by one cycle.
// - Assert rst_n low after beat 2 of a refill:
//   - Expect all outputs to return to reset values immediately.
//   - A retried pc misses and refills cleanly.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, request/response payload layouts and FSM state encoding for the icache read server
package icache_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int WAVE_ID_W = 4;
  localparam int ICACHE_REQ_SIZE = WAVE_ID_W + ADDR_WIDTH;
  localparam int ICACHE_RESP_SIZE = ICACHE_REQ_SIZE + 32;
  typedef struct packed {
    logic [WAVE_ID_W-1:0]  wave_id;
    logic [ADDR_WIDTH-1:0] pc;
  } icache_req_t;
  typedef struct packed {
    logic [WAVE_ID_W-1:0]  wave_id;
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           inst;
  } icache_resp_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP,
    S_REFILL_REQ,
    S_REFILL_WAIT
  } icache_state_e;
endpackage

// File: rtl/icache_rd_server_if.sv
// decoupled_intr: valid/ready stream carrying a W-bit payload
interface decoupled_intr #(parameter int W = 32);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  modport master(output valid, output data, input ready);
  modport slave(input valid, input data, output ready);
endinterface

// File: rtl/icache_data_ram.sv
// icache_data_ram: single-port synchronous word RAM with 1-cycle read latency
module icache_data_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/icache_rd_server.sv
// icache_rd_server: blocking direct-mapped instruction cache returning one dword per wave fetch request
module icache_rd_server
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int LINE_WORDS = 4
) (
  input logic           clk,
  input logic           rst_n,
  decoupled_intr.slave  icache_rd_req,
  decoupled_intr.master icache_rd_resp,
  decoupled_intr.master mem_rd_req,
  decoupled_intr.slave  mem_rd_resp,
  input logic           inv_all
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_WIDTH - 2 - OW - IW;
  icache_state_e state, state_nx;
  icache_req_t req_in, req_q;
  icache_resp_t resp_q;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0] tags [NUM_LINES];
  logic [OW-1:0] beat, off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [IW+OW-1:0] ram_addr;
  logic [31:0] rdata;
  logic live, inv_pending, accept, hit, beat_fire, last, resp_done, inv_clr;
  assign req_in = icache_rd_req.data;
  assign off = req_q.pc[2 +: OW];
  assign idx = req_q.pc[2+OW +: IW];
  assign tag = req_q.pc[ADDR_WIDTH-1 -: TW];
  // live keeps ready low while rst_n is asserted, since the FSM already sits in IDLE then
  assign icache_rd_req.ready = live && state == S_IDLE && !inv_pending && !inv_all;
  assign accept = icache_rd_req.valid && icache_rd_req.ready;
  assign hit = valid[idx] && tags[idx] == tag;
  assign beat_fire = state == S_REFILL_WAIT && mem_rd_resp.valid;
  assign last = beat_fire && beat == OW'(LINE_WORDS - 1);
  assign resp_done = state == S_RESP && icache_rd_resp.ready;
  assign inv_clr = (state == S_IDLE || resp_done) && (inv_all || inv_pending);
  assign icache_rd_resp.valid = state == S_RESP;
  assign icache_rd_resp.data = resp_q;
  assign mem_rd_req.valid = state == S_REFILL_REQ;
  assign mem_rd_req.data = state == S_REFILL_REQ ? {req_q.pc[ADDR_WIDTH-1:2+OW], {(2+OW){1'b0}}} : '0;
  assign mem_rd_resp.ready = state == S_REFILL_WAIT;
  assign ram_addr = state == S_REFILL_WAIT ? {idx, beat} : req_in.pc[2 +: IW+OW];
  always_comb
    state_nx = state == S_IDLE       ? (accept ? S_LOOKUP : S_IDLE) :
               state == S_LOOKUP     ? (hit ? S_RESP : S_REFILL_REQ) :
               state == S_RESP       ? (resp_done ? S_IDLE : S_RESP) :
               state == S_REFILL_REQ ? (mem_rd_req.ready ? S_REFILL_WAIT : S_REFILL_REQ) :
                                       (last ? S_RESP : S_REFILL_WAIT);
  icache_data_ram #(.DEPTH(NUM_LINES * LINE_WORDS)) u_ram (
    .clk  (clk),
    .we   (beat_fire),
    .addr (ram_addr),
    .wdata(mem_rd_resp.data),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      live <= 1'b0;
      inv_pending <= 1'b0;
      valid <= '0;
      beat <= '0;
      req_q <= '0;
      resp_q <= '0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      inv_pending <= !inv_clr && (inv_pending || inv_all);
      if (accept) req_q <= req_in;
      if (state == S_LOOKUP && hit) resp_q <= {req_q, rdata};
      if (beat_fire && beat == off) resp_q <= {req_q, mem_rd_resp.data};
      if (state == S_REFILL_REQ && mem_rd_req.ready) begin
        beat <= '0;
        valid[idx] <= 1'b0;
      end
      if (beat_fire) beat <= last ? '0 : beat + 1'b1;
      if (last) valid[idx] <= 1'b1;
      if (inv_clr) valid <= '0;
    end
  always_ff @(posedge clk)
    if (last) tags[idx] <= tag;
endmodule

// File: tb/tb_icache_rd_server.sv
// tb_icache_rd_server: directed fetch scenarios checked against a line-level cache model and a per-cycle monitor
module tb_icache_rd_server;
  import icache_pkg::*;
  localparam int NL = 64;
  localparam int LW = 4;
  logic clk = 0, rst_n = 0, inv_all = 0;
  int tests = 0, fails = 0, cyc = 0;
  bit mvalid [NL];
  logic [21:0] mtag [NL];
  logic [67:0] exp_resp = '0;
  logic [31:0] exp_line = '0;
  decoupled_intr #(.W(ICACHE_REQ_SIZE)) req_if ();
  decoupled_intr #(.W(ICACHE_RESP_SIZE)) resp_if ();
  decoupled_intr #(.W(ADDR_WIDTH)) mreq_if ();
  decoupled_intr #(.W(32)) mresp_if ();
  icache_rd_server #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icache_rd_req (req_if),
    .icache_rd_resp(resp_if),
    .mem_rd_req    (mreq_if),
    .mem_rd_resp   (mresp_if),
    .inv_all       (inv_all)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // backing store: line 0x100 holds A0..A3, everything else is address-derived
  function automatic logic [31:0] backing(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    return (w[31:4] == 28'h10) ? 32'hA0 + {30'b0, w[3:2]} : 32'hD000_0000 ^ w;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear;
    foreach (mvalid[i]) mvalid[i] = 0;
  endtask
  task automatic check_reset_outputs;
    check("rst_req_ready", req_if.ready, 0);
    check("rst_resp_valid", resp_if.valid, 0);
    check("rst_resp_data", resp_if.data, 0);
    check("rst_mem_req_valid", mreq_if.valid, 0);
    check("rst_mem_req_data", mreq_if.data, 0);
    check("rst_mem_resp_ready", mresp_if.ready, 0);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (resp_if.valid) begin
        check("resp_data", resp_if.data, exp_resp);
        check("req_ready_busy", req_if.ready, 0);
      end
      if (mreq_if.valid) check("mem_addr", mreq_if.data, exp_line);
    end
  task automatic transact(input logic [3:0] w, input logic [31:0] pc, input int bp, input int inv_beat,
                          input int abort_after, input bit inv_idle, input bit use_lit, input logic [67:0] lit);
    int n, t_acc, t_last;
    bit hit;
    logic [31:0] line;
    line = pc & ~32'hF;
    req_if.valid = 1;
    req_if.data = {w, pc};
    if (inv_idle) begin
      inv_all = 1;
      #1;
      check("inv_blocks_ready", req_if.ready, 0);
      step;
      inv_all = 0;
      model_clear;
      #1;
      check("ready_after_inv", req_if.ready, 1);
    end
    n = 0;
    while (!req_if.ready && n < 20) begin step; n++; end
    if (!req_if.ready) begin check("accept_timeout", 0, 1); req_if.valid = 0; return; end
    t_acc = cyc;
    hit = mvalid[pc[9:4]] && mtag[pc[9:4]] == pc[31:10];
    exp_resp = {w, pc, backing(pc)};
    exp_line = line;
    step;
    req_if.valid = 0;
    if (hit) begin
      n = 0;
      while (!resp_if.valid && n < 20) begin
        check("hit_no_memreq", mreq_if.valid, 0);
        step;
        n++;
      end
      check("hit_no_memreq", mreq_if.valid, 0);
      check("hit_latency", 128'(cyc - t_acc), 2);
    end else begin
      n = 0;
      while (!mreq_if.valid && n < 20) begin step; n++; end
      check("miss_memreq_seen", mreq_if.valid, 1);
      step;
      t_last = cyc;
      for (int b = 0; b < LW; b++) begin
        if (abort_after == b) begin
          mresp_if.valid = 0;
          rst_n = 0;
          #1;
          check_reset_outputs;
          step;
          step;
          rst_n = 1;
          model_clear;
          return;
        end
        n = 0;
        while (!mresp_if.ready && n < 20) begin step; n++; end
        mresp_if.valid = 1;
        mresp_if.data = backing(line + 32'(4 * b));
        inv_all = (b == inv_beat);
        t_last = cyc;
        step;
      end
      mresp_if.valid = 0;
      inv_all = 0;
      n = 0;
      while (!resp_if.valid && n < 20) begin step; n++; end
      check("miss_latency", 128'(cyc - t_last), 1);
      mvalid[pc[9:4]] = 1;
      mtag[pc[9:4]] = pc[31:10];
      if (inv_beat >= 0) model_clear;
    end
    check("resp_valid", resp_if.valid, 1);
    if (use_lit) check("resp_literal", resp_if.data, lit);
    repeat (bp) begin
      step;
      check("bp_hold_valid", resp_if.valid, 1);
    end
    resp_if.ready = 1;
    step;
    resp_if.ready = 0;
    check("resp_released", resp_if.valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    req_if.valid = 0;
    req_if.data = '0;
    resp_if.ready = 0;
    mreq_if.ready = 1;
    mresp_if.valid = 0;
    mresp_if.data = '0;
    model_clear;
    #1;
    check_reset_outputs;
    step;
    step;
    rst_n = 1;
    step;
    transact(4'd3, 32'h100, 0, -1, -1, 0, 1, {4'd3, 32'h100, 32'hA0});
    transact(4'd5, 32'h108, 0, -1, -1, 0, 1, {4'd5, 32'h108, 32'hA2});
    transact(4'd1, 32'h500, 0, -1, -1, 0, 0, '0);
    transact(4'd2, 32'h100, 0, -1, -1, 0, 1, {4'd2, 32'h100, 32'hA0});
    transact(4'd7, 32'h104, 10, -1, -1, 0, 1, {4'd7, 32'h104, 32'hA1});
    transact(4'd4, 32'h20C, 0, 1, -1, 0, 0, '0);
    transact(4'd4, 32'h20C, 0, -1, -1, 0, 0, '0);
    transact(4'd6, 32'h030, 0, -1, -1, 1, 0, '0);
    transact(4'd8, 32'h400, 0, -1, 3, 0, 0, '0);
    transact(4'd8, 32'h400, 0, -1, -1, 0, 0, '0);
    transact(4'd9, 32'h100, 0, -1, -1, 0, 1, {4'd9, 32'h100, 32'hA0});
    transact(4'd10, 32'h404, 0, -1, -1, 0, 0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
